vco_freq_lock: RTL

//  Successive-approximation frequency-lock controller for the vco block. It drives the VCO control word
//  (voltage_ctrl_i of vco) and counts VCO ticks over a fixed reference window. It binary-searches the code

---
 rtl/vco_freq_lock.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/vco_freq_lock.sv
// rtl/vco_freq_lock.sv - successive-approximation VCO frequency-lock controller
//
// Binary-searches the VCO control word so that the number of VCO ticks counted
// over a fixed reference window is the largest count not above the programmed target.
//
// Ports:
//   clk_i          reference clock
//   arst_ni        asynchronous active-low reset
//   start_i        start a lock sequence (accepted in IDLE only)
//   abort_i        abandon a running sequence
//   target_count_i expected ticks per window, latched at start
//   vco_tick_i     one-cycle pulse per (prescaled) VCO period, synchronous to clk_i
//   voltage_ctrl_o VCO control word
//   busy_o         sequence in progress
//   done_o         one-cycle pulse at sequence completion
//   locked_o       final count within TOLERANCE of target
//   meas_count_o   tick count of the most recent completed window
module vco_freq_lock #(
  parameter int RESOLUTION_BITS = 30,
  parameter int CNT_W           = 16,
  parameter int WINDOW_CYCLES   = 1000,
  parameter int SETTLE_CYCLES   = 16,
  parameter int TOLERANCE       = 1
) (
  input  logic                       clk_i,
  input  logic                       arst_ni,
  input  logic                       start_i,
  input  logic                       abort_i,
  input  logic [CNT_W-1:0]           target_count_i,
  input  logic                       vco_tick_i,
  output logic [RESOLUTION_BITS-1:0] voltage_ctrl_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       locked_o,
  output logic [CNT_W-1:0]           meas_count_o
);

  localparam int PH_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int K_W    = (RESOLUTION_BITS > 1) ? $clog2(RESOLUTION_BITS) : 1;

  localparam logic [PH_W-1:0]            SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);
  localparam logic [PH_W-1:0]            WINDOW_LAST = PH_W'(WINDOW_CYCLES - 1);
  localparam logic [K_W-1:0]             K_TOP       = K_W'(RESOLUTION_BITS - 1);
  localparam logic [CNT_W-1:0]           CNT_MAX     = '1;
  localparam logic [CNT_W:0]             TOL         = (CNT_W + 1)'(TOLERANCE);
  localparam logic [RESOLUTION_BITS-1:0] CODE_ONE    = RESOLUTION_BITS'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_DECIDE,
    S_DONE
  } state_t;

  state_t                     state_q, state_d;
  logic [PH_W-1:0]            phase_q;
  logic [CNT_W-1:0]           count_q;
  logic [CNT_W-1:0]           target_q;
  logic [K_W-1:0]             k_q;
  logic                       final_q;
  logic [CNT_W:0]             diff;
  logic [RESOLUTION_BITS-1:0] trial_code;
  logic                       aborting;

  assign aborting = (state_q != S_IDLE) && abort_i;

  // Absolute distance between the last count and the target, one bit wider
  // so the tolerance compare never overflows.
  always_comb begin
    diff = '0;
    if (count_q >= target_q) diff = {1'b0, count_q - target_q};
    else                     diff = {1'b0, target_q - count_q};
  end

  // Next code for a non-final decision: drop the bit under test if the VCO ran
  // too fast, then arm the next lower bit (if any) as the new trial.
  always_comb begin
    trial_code = voltage_ctrl_o;
    if (count_q > target_q) trial_code[k_q] = 1'b0;
    if (k_q != '0)          trial_code[k_q - 1'b1] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy_o  = (state_q != S_IDLE);
    done_o  = (state_q == S_DONE) && !abort_i;
    case (state_q)
      S_IDLE:    if (start_i) state_d = S_SETTLE;
      S_SETTLE:  if (phase_q == SETTLE_LAST) state_d = S_MEASURE;
      S_MEASURE: if (phase_q == WINDOW_LAST) state_d = S_DECIDE;
      S_DECIDE:  state_d = final_q ? S_DONE : S_SETTLE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (aborting) state_d = S_IDLE;
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      phase_q        <= '0;
      count_q        <= '0;
      target_q       <= '0;
      k_q            <= '0;
      final_q        <= 1'b0;
      voltage_ctrl_o <= '0;
      locked_o       <= 1'b0;
      meas_count_o   <= '0;
    end else begin
      // Phase counter restarts on every state change so each SETTLE and
      // MEASURE visit lasts exactly its programmed length.
      if (state_d != state_q)
        phase_q <= '0;
      else if (state_q == S_SETTLE || state_q == S_MEASURE)
        phase_q <= phase_q + 1'b1;

      if (state_q == S_SETTLE)
        count_q <= '0;
      else if (state_q == S_MEASURE && vco_tick_i && count_q != CNT_MAX)
        count_q <= count_q + 1'b1;

      if (state_q == S_IDLE && start_i) begin
        target_q       <= target_count_i;
        k_q            <= K_TOP;
        voltage_ctrl_o <= CODE_ONE << K_TOP;
        locked_o       <= 1'b0;
        final_q        <= 1'b0;
      end else if (aborting) begin
        locked_o <= 1'b0;
      end else if (state_q == S_DECIDE) begin
        meas_count_o <= count_q;
        if (!final_q) begin
          voltage_ctrl_o <= trial_code;
          if (k_q != '0) k_q <= k_q - 1'b1;
          else           final_q <= 1'b1;  // one more pass to measure the final code
        end else begin
          locked_o <= (diff <= TOL);
        end
      end
    end
  end

endmodule
